stall_ctrl: RTL

STALL_CTRL -- requirements
Module: stall_ctrl

---
 rtl/stall_ctrl.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : stall_ctrl
// Purpose  : Pipeline stall/flush controller for jumps, load-use hazards and
//            data-memory wait states. Optional perf counters: STALL_PERF_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module stall_ctrl #(
    parameter int JUMP_BUBBLES = 2,
    parameter int MEM_TIMEOUT  = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        jump_req,
    input  logic [31:0] jump_target,
    input  logic        load_use_req,
    input  logic        mem_busy,
    output logic        if_stall,
    output logic        ifid_hold,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        pc_redirect,
    output logic [31:0] pc_target,
    output logic        mem_timeout,
    output logic [1:0]  state_o
`ifdef STALL_PERF_CNT_EN
    ,
    output logic [31:0] jump_stall_cnt,
    output logic [31:0] mem_stall_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_MEMW  = 2'd2,
        ST_LDUSE = 2'd3
    } state_t;

    localparam logic [2:0] C_BUB_RELOAD = 3'(JUMP_BUBBLES - 1);
    localparam state_t     C_JUMP_NEXT  = (JUMP_BUBBLES > 1) ? ST_FLUSH : ST_RUN;
    localparam logic [7:0] C_TIMEOUT    = 8'(MEM_TIMEOUT);

    state_t      r_state;
    logic [2:0]  r_bub_cnt;
    logic        r_pend_valid;
    logic [31:0] r_pend_target;
    logic [7:0]  r_busy_cnt;
    logic        r_timeout;

    state_t      w_next_state;
    logic [2:0]  w_next_bub;
    logic        w_next_pend_valid;
    logic [31:0] w_next_pend_target;
    logic [7:0]  w_next_busy;
    logic        w_if_stall;
    logic        w_ifid_hold;
    logic        w_ifid_flush;
    logic        w_idex_flush;
    logic        w_redirect;
    logic [31:0] w_target;

    always_comb begin
        w_next_state       = r_state;
        w_next_bub         = r_bub_cnt;
        w_next_pend_valid  = r_pend_valid;
        w_next_pend_target = r_pend_target;
        w_if_stall         = 1'b0;
        w_ifid_hold        = 1'b0;
        w_ifid_flush       = 1'b0;
        w_idex_flush       = 1'b0;
        w_redirect         = 1'b0;
        w_target           = 32'd0;

        if (mem_busy) begin
            // Everything freezes; a jump resolved now is parked until memory frees up.
            w_if_stall   = 1'b1;
            w_ifid_hold  = 1'b1;
            w_next_state = ST_MEMW;
            if (jump_req) begin
                w_next_pend_valid  = 1'b1;
                w_next_pend_target = jump_target;
            end
        end else if (jump_req || r_pend_valid) begin
            w_redirect        = 1'b1;
            w_target          = jump_req ? jump_target : r_pend_target;
            w_ifid_flush      = 1'b1;
            w_idex_flush      = 1'b1;
            w_next_bub        = C_BUB_RELOAD;
            w_next_state      = C_JUMP_NEXT;
            w_next_pend_valid = 1'b0;
        end else if (r_bub_cnt != 3'd0) begin
            // Remaining bubbles of a jump, possibly resumed after a memory wait.
            w_ifid_flush = 1'b1;
            w_next_bub   = r_bub_cnt - 3'd1;
            w_next_state = (r_bub_cnt == 3'd1) ? ST_RUN : ST_FLUSH;
        end else if (r_state == ST_LDUSE) begin
            w_next_state = ST_RUN;
        end else if (load_use_req) begin
            w_if_stall   = 1'b1;
            w_ifid_hold  = 1'b1;
            w_idex_flush = 1'b1;
            w_next_state = ST_LDUSE;
        end else begin
            w_next_state = ST_RUN;
        end
    end

    always_comb begin
        w_next_busy = 8'd0;
        if (mem_busy) begin
            w_next_busy = (r_busy_cnt == 8'hFF) ? 8'hFF : r_busy_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_RUN;
            r_bub_cnt     <= 3'd0;
            r_pend_valid  <= 1'b0;
            r_pend_target <= 32'd0;
            r_busy_cnt    <= 8'd0;
            r_timeout     <= 1'b0;
        end else begin
            r_state       <= w_next_state;
            r_bub_cnt     <= w_next_bub;
            r_pend_valid  <= w_next_pend_valid;
            r_pend_target <= w_next_pend_target;
            r_busy_cnt    <= w_next_busy;
            r_timeout     <= r_timeout | (w_next_busy >= C_TIMEOUT);
        end
    end

    // Outputs are forced low while reset is held, even with live inputs.
    assign if_stall    = rst_n & w_if_stall;
    assign ifid_hold   = rst_n & w_ifid_hold;
    assign ifid_flush  = rst_n & w_ifid_flush;
    assign idex_flush  = rst_n & w_idex_flush;
    assign pc_redirect = rst_n & w_redirect;
    assign pc_target   = rst_n ? w_target : 32'd0;
    assign mem_timeout = r_timeout;
    assign state_o     = r_state;

`ifdef STALL_PERF_CNT_EN
    logic [31:0] r_jump_stall_cnt;
    logic [31:0] r_mem_stall_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_jump_stall_cnt <= 32'd0;
            r_mem_stall_cnt  <= 32'd0;
        end else begin
            r_jump_stall_cnt <= r_jump_stall_cnt + {31'd0, w_ifid_flush};
            r_mem_stall_cnt  <= r_mem_stall_cnt + {31'd0, mem_busy};
        end
    end

    assign jump_stall_cnt = r_jump_stall_cnt;
    assign mem_stall_cnt  = r_mem_stall_cnt;
`endif

endmodule
`default_nettype wire
